// File: rtl/ffo_normalizer_pipe.sv
// Pipelined find-first-one and normaliser: nibble-level detect, then priority merge and barrel shift.
// DIR selects leading-one (0) or trailing-one (1); STAGES selects a 1- or 2-deep pipeline.
module ffo_normalizer_pipe #(
  parameter int N      = 24,
  parameter int STAGES = 2,
  parameter int DIR    = 0,
  localparam int IDX_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_word,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_found,
  output logic [IDX_W-1:0] out_index,
  output logic [IDX_W-1:0] out_shift,
  output logic [N-1:0]     out_norm
);

  localparam int NIB   = (N + 3) / 4;
  localparam int PAD_W = 4 * NIB;

  function automatic logic [1:0] nib_sub(input logic [3:0] nib);
    logic [1:0] sub;
    sub = 2'd0;
    // The last hit in scan order wins: ascending for highest, descending for lowest.
    for (int b = 0; b < 4; b++) begin
      if (nib[(DIR == 0) ? b : 3 - b]) sub = 2'((DIR == 0) ? b : 3 - b);
    end
    return sub;
  endfunction

  logic [PAD_W-1:0]      pad_word;
  logic [NIB-1:0]        nv_c;
  logic [NIB-1:0][1:0]   ns_c;

  // Zero padding of the top nibble can never create a hit.
  assign pad_word = PAD_W'(in_word);

  for (genvar k = 0; k < NIB; k++) begin : g_nib
    assign nv_c[k] = |pad_word[4*k +: 4];
    assign ns_c[k] = nib_sub(pad_word[4*k +: 4]);
  end

  logic                src_valid;
  logic [N-1:0]        src_word;
  logic [NIB-1:0]      src_nv;
  logic [NIB-1:0][1:0] src_ns;
  logic                load_out;

  assign load_out = !out_valid || out_ready;

  if (STAGES == 1) begin : g_s1
    assign src_valid = in_valid;
    assign src_word  = in_word;
    assign src_nv    = nv_c;
    assign src_ns    = ns_c;
    assign in_ready  = load_out;
  end else begin : g_s2
    logic                vld_p1;
    logic [N-1:0]        word_p1;
    logic [NIB-1:0]      nv_p1;
    logic [NIB-1:0][1:0] ns_p1;

    assign in_ready = !vld_p1 || load_out;

    // ---- stage 1 boundary: per-nibble valid and sub-index ----
    always_ff @(posedge clk) begin
      if (reset) begin
        vld_p1 <= 1'b0;
      end else if (in_ready) begin
        vld_p1 <= in_valid;
      end
    end

    always_ff @(posedge clk) begin
      if (in_valid && in_ready) begin
        word_p1 <= in_word;
        nv_p1   <= nv_c;
        ns_p1   <= ns_c;
      end
    end

    assign src_valid = vld_p1;
    assign src_word  = word_p1;
    assign src_nv    = nv_p1;
    assign src_ns    = ns_p1;
  end

  logic             found_c;
  logic [IDX_W-1:0] index_c;
  logic [IDX_W-1:0] shift_c;
  logic [N-1:0]     norm_c;

  always_comb begin : p_resolve
    int kk;
    found_c = 1'b0;
    index_c = '0;
    shift_c = '0;
    norm_c  = '0;
    kk      = 0;
    for (int k = 0; k < NIB; k++) begin
      kk = (DIR == 0) ? k : NIB - 1 - k;
      if (src_nv[kk]) begin
        found_c = 1'b1;
        index_c = IDX_W'(4 * kk + int'(src_ns[kk]));
      end
    end
    if (found_c) begin
      shift_c = (DIR == 0) ? IDX_W'(N - 1) - index_c : index_c;
      norm_c  = (DIR == 0) ? (src_word << shift_c) : (src_word >> shift_c);
    end
  end

  // ---- output stage boundary: index, shift and normalised word ----
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_found <= 1'b0;
      out_index <= '0;
      out_shift <= '0;
      out_norm  <= '0;
    end else if (load_out) begin
      out_valid <= src_valid;
      if (src_valid) begin
        out_found <= found_c;
        out_index <= index_c;
        out_shift <= shift_c;
        out_norm  <= norm_c;
      end
    end
  end

endmodule

// File: tb/tb_ffo_normalizer_pipe.sv
// Bench for ffo_normalizer_pipe: directed table, streaming, backpressure, reset and random scoreboard.
// Three instances cover N=24/DIR=0/2-stage, N=24/DIR=1/2-stage and N=13/DIR=0/1-stage.
module tb_ffo_normalizer_pipe;

  logic clk = 1'b0;
  logic reset;

  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_found;
  logic [23:0] a_in_word, a_out_norm;
  logic [4:0]  a_out_index, a_out_shift;

  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_found;
  logic [23:0] b_in_word, b_out_norm;
  logic [4:0]  b_out_index, b_out_shift;

  logic        c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_out_found;
  logic [12:0] c_in_word, c_out_norm;
  logic [3:0]  c_out_index, c_out_shift;

  ffo_normalizer_pipe #(.N(24), .STAGES(2), .DIR(0)) dut_a (
    .clk(clk), .reset(reset), .in_valid(a_in_valid), .in_ready(a_in_ready), .in_word(a_in_word),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_found(a_out_found),
    .out_index(a_out_index), .out_shift(a_out_shift), .out_norm(a_out_norm));

  ffo_normalizer_pipe #(.N(24), .STAGES(2), .DIR(1)) dut_b (
    .clk(clk), .reset(reset), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_word(b_in_word),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_found(b_out_found),
    .out_index(b_out_index), .out_shift(b_out_shift), .out_norm(b_out_norm));

  ffo_normalizer_pipe #(.N(13), .STAGES(1), .DIR(0)) dut_c (
    .clk(clk), .reset(reset), .in_valid(c_in_valid), .in_ready(c_in_ready), .in_word(c_in_word),
    .out_valid(c_out_valid), .out_ready(c_out_ready), .out_found(c_out_found),
    .out_index(c_out_index), .out_shift(c_out_shift), .out_norm(c_out_norm));

  initial forever #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain bit scan over the real N bits, result packed as {found, index, shift, norm}.
  function automatic logic [63:0] model(input logic [63:0] w, input int n, input int dir);
    logic [63:0] mask, ww, norm;
    logic        found;
    int          idx, sh;
    mask  = (64'd1 << n) - 64'd1;
    ww    = w & mask;
    found = 1'b0;
    idx   = 0;
    sh    = 0;
    norm  = 64'd0;
    for (int i = 0; i < n; i++) begin
      if (ww[i] && (dir == 0 || !found)) begin
        idx   = i;
        found = 1'b1;
      end
    end
    if (found) begin
      sh   = (dir == 0) ? n - 1 - idx : idx;
      norm = (dir == 0) ? ((ww << sh) & mask) : (ww >> sh);
    end
    return {29'd0, found, 5'(idx), 5'(sh), norm[23:0]};
  endfunction

  function automatic logic [63:0] pack(input int sel);
    if (sel == 0) return {29'd0, a_out_found, a_out_index, a_out_shift, a_out_norm};
    if (sel == 1) return {29'd0, b_out_found, b_out_index, b_out_shift, b_out_norm};
    return {29'd0, c_out_found, 1'b0, c_out_index, 1'b0, c_out_shift, 11'd0, c_out_norm};
  endfunction

  typedef struct {
    int          sel;
    logic [23:0] word;
    logic        found;
    logic [4:0]  idx;
    logic [4:0]  sh;
    logic [23:0] norm;
  } vec_t;

  function automatic logic [63:0] exp_of(input vec_t v);
    return {29'd0, v.found, v.idx, v.sh, v.norm};
  endfunction

  // Send one word to the selected instance with out_ready high and sample at its latency.
  task automatic apply(input int sel, input logic [23:0] w,
                       output logic [63:0] res, output logic vld_early, output logic vld);
    case (sel)
      0:       begin a_in_valid = 1'b1; a_in_word = w; end
      1:       begin b_in_valid = 1'b1; b_in_word = w; end
      default: begin c_in_valid = 1'b1; c_in_word = w[12:0]; end
    endcase
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    b_in_valid = 1'b0;
    c_in_valid = 1'b0;
    vld_early = (sel == 0) ? a_out_valid : (sel == 1) ? b_out_valid : c_out_valid;
    if (sel != 2) begin
      @(posedge clk); #1;
    end
    vld = (sel == 0) ? a_out_valid : (sel == 1) ? b_out_valid : c_out_valid;
    res = pack(sel);
  endtask

  // Scoreboard for instance a: expected results queued at input transfer, checked at output transfer.
  logic [63:0] sb_q[$];
  logic [63:0] held;
  bit          stall_chk = 0;
  int          a_rx = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        sb_q.delete();
        stall_chk = 0;
      end else begin
        if (stall_chk) begin
          check("stall_valid", 64'(a_out_valid), 64'd1);
          check("stall_hold", pack(0), held);
        end
        if (a_out_valid && a_out_ready) begin
          a_rx++;
          if (sb_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL sb_extra: got %0h expected no result", pack(0));
          end else begin
            check("sb_order", pack(0), sb_q.pop_front());
          end
        end
        stall_chk = a_out_valid && !a_out_ready;
        held = pack(0);
        if (a_in_valid && a_in_ready) sb_q.push_back(model(64'(a_in_word), 24, 0));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  vec_t        tbl[13];
  logic [63:0] res;
  logic        v_early, v;
  logic [23:0] w;
  logic [23:0] bp[4];
  int          sent, rx0;
  bit          acc;

  initial begin
    tbl[0]  = '{0, 24'h000100, 1'b1, 5'd8,  5'd15, 24'h800000};
    tbl[1]  = '{0, 24'h800000, 1'b1, 5'd23, 5'd0,  24'h800000};
    tbl[2]  = '{0, 24'h00000F, 1'b1, 5'd3,  5'd20, 24'hF00000};
    tbl[3]  = '{0, 24'h000000, 1'b0, 5'd0,  5'd0,  24'h000000};
    tbl[4]  = '{0, 24'h000001, 1'b1, 5'd0,  5'd23, 24'h800000};
    tbl[5]  = '{0, 24'h5A0000, 1'b1, 5'd22, 5'd1,  24'hB40000};
    tbl[6]  = '{0, 24'hFFFFFF, 1'b1, 5'd23, 5'd0,  24'hFFFFFF};
    tbl[7]  = '{1, 24'h0A0000, 1'b1, 5'd17, 5'd17, 24'h000005};
    tbl[8]  = '{1, 24'h800000, 1'b1, 5'd23, 5'd23, 24'h000001};
    tbl[9]  = '{1, 24'h000000, 1'b0, 5'd0,  5'd0,  24'h000000};
    tbl[10] = '{2, 24'h001000, 1'b1, 5'd12, 5'd0,  24'h001000};
    tbl[11] = '{2, 24'h000001, 1'b1, 5'd0,  5'd12, 24'h001000};
    tbl[12] = '{2, 24'h000FFF, 1'b1, 5'd11, 5'd1,  24'h001FFE};
    bp[0] = 24'h000100; bp[1] = 24'h400000; bp[2] = 24'h000003; bp[3] = 24'h0F0F00;

    reset = 1'b1;
    a_in_valid = 1'b0; b_in_valid = 1'b0; c_in_valid = 1'b0;
    a_in_word = '0; b_in_word = '0; c_in_word = '0;
    a_out_ready = 1'b1; b_out_ready = 1'b1; c_out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    check("rst_out_valid", 64'(a_out_valid), 64'd0);
    check("rst_outputs", pack(0), 64'd0);
    check("rst_in_ready", 64'(a_in_ready), 64'd1);
    check("rst_in_ready_c", 64'(c_in_ready), 64'd1);

    for (int i = 0; i < 13; i++) begin
      apply(tbl[i].sel, tbl[i].word, res, v_early, v);
      if (tbl[i].sel != 2) check("tbl_latency_early", 64'(v_early), 64'd0);
      check("tbl_valid", 64'(v), 64'd1);
      check("tbl_result", res, exp_of(tbl[i]));
    end

    // Back-to-back stream: results appear on consecutive cycles.
    for (int i = 0; i < 5; i++) begin
      if (i < 3) begin
        a_in_valid = 1'b1;
        a_in_word  = tbl[i + 1].word;
      end else begin
        a_in_valid = 1'b0;
      end
      @(posedge clk); #1;
      if (i >= 1 && i <= 3) begin
        check("stream_valid", 64'(a_out_valid), 64'd1);
        check("stream_result", pack(0), exp_of(tbl[i]));
      end
    end
    a_in_valid = 1'b0;

    // Backpressure: 5 stalled cycles with 4 words offered.
    a_out_ready = 1'b0;
    sent = 0;
    a_in_valid = 1'b1;
    a_in_word = bp[0];
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      acc = a_in_valid && a_in_ready;
      @(posedge clk); #1;
      if (acc) sent++;
      a_in_valid = (sent < 4);
      a_in_word  = bp[sent % 4];
    end
    check("bp_accepted", 64'(sent), 64'd2);
    check("bp_in_ready_low", 64'(a_in_ready), 64'd0);
    check("bp_out_valid", 64'(a_out_valid), 64'd1);
    rx0 = a_rx;
    a_out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("bp_no_gap", 64'(a_out_valid), 64'd1);
      acc = a_in_valid && a_in_ready;
      @(posedge clk); #1;
      if (acc) sent++;
      a_in_valid = (sent < 4);
      a_in_word  = bp[sent % 4];
    end
    check("bp_sent", 64'(sent), 64'd4);
    check("bp_rx", 64'(a_rx - rx0), 64'd4);
    @(negedge clk);
    check("bp_empty", 64'(a_out_valid), 64'd0);
    @(posedge clk); #1;

    // Reset with two words in flight.
    a_out_ready = 1'b0;
    a_in_valid = 1'b1;
    a_in_word = 24'h000400;
    @(posedge clk); #1;
    a_in_word = 24'h020000;
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    check("rst_mid_pre_valid", 64'(a_out_valid), 64'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("rst_mid_out_valid", 64'(a_out_valid), 64'd0);
    check("rst_mid_in_ready", 64'(a_in_ready), 64'd1);
    check("rst_mid_outputs", pack(0), 64'd0);
    a_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("rst_no_stale", 64'(a_out_valid), 64'd0);
    end
    apply(0, 24'h000040, res, v_early, v);
    check("rst_next_valid", 64'(v), 64'd1);
    check("rst_next_result", res, {29'd0, 1'b1, 5'd6, 5'd17, 24'h800000});

    // Random single words on the DIR=1 and N=13 instances.
    for (int i = 0; i < 30; i++) begin
      w = 24'($urandom() >> $urandom_range(0, 24));
      apply(1, w, res, v_early, v);
      check("b_rand_valid", 64'(v), 64'd1);
      check("b_rand_result", res, model(64'(w), 24, 1));
      w = 24'(($urandom() & 32'h1FFF) >> $urandom_range(0, 13));
      apply(2, w, res, v_early, v);
      check("c_rand_valid", 64'(v), 64'd1);
      check("c_rand_result", res, model(64'(w), 13, 0));
    end

    // Random traffic with random backpressure on instance a, checked by the scoreboard.
    for (int i = 0; i < 300; i++) begin
      a_in_valid  = ($urandom_range(0, 3) != 0);
      a_in_word   = 24'($urandom() >> $urandom_range(0, 24));
      a_out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    a_in_valid = 1'b0;
    a_out_ready = 1'b1;
    for (int t = 0; t < 20; t++) begin
      if (sb_q.size() == 0) break;
      @(negedge clk);
    end
    check("drain_empty", 64'(sb_q.size()), 64'd0);
    @(posedge clk); #1;
    check("drain_out_valid", 64'(a_out_valid), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ffo_normalizer_pipe.md
Name: ffo_normalizer_pipe

Overview:
Pipelined, parametrised find-first-one and normalise unit for the fixed-point adder datapath, generalising the 24-bit combinational leading-one detector.
- Accepts an N-bit word per cycle over a valid/ready handshake.
- Locates the leading (or trailing) set bit.
- Returns its index, the shift distance, and the normalised word.
- Sits between the adder core and the result-packing stage, so the normaliser can be retimed without touching adder logic.

Parameters:
- N, 24: input word width; legal range 4..64, any value (not only multiples of 4).
- STAGES, 2: register stages, 1 or 2.
- DIR, 0: 0 = leading-one (highest set bit); 1 = trailing-one (lowest set bit).
- IDX_W, $clog2(N) (localparam): index and shift width.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  input word present.
- in_ready  out  1  unit accepts a word this cycle.
- in_word  in  N  word to search.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts the result.
- out_found  out  1  at least one bit of the word was set.
- out_index  out  IDX_W  bit position of the found one.
- out_shift  out  IDX_W  DIR=0: N-1-index; DIR=1: index.
- out_norm  out  N  DIR=0: word<<out_shift; DIR=1: word>>out_shift.

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high.
- Reset values:
  - All stage valid flags cleared.
  - out_valid=0, out_found=0, out_index=0, out_shift=0, out_norm=0.
  - in_ready=1 in the cycle after reset deasserts.
- Transfer rule: a transfer occurs on a rising edge where valid&ready are both high, at both the input and the output.
- Latency: exactly STAGES cycles from input transfer to out_valid with no backpressure. Throughput is one word per cycle.
- Stage 1:
  - Split the word into ceil(N/4) nibbles; the top nibble is zero-padded when N%4≠0.
  - Per nibble, register a nibble-valid bit and a 2-bit sub-index: highest set bit for DIR=0, lowest for DIR=1.
  - Register the word alongside.
- Stage 2 (merged into stage 1 when STAGES=1):
  - Priority-select the winning nibble: highest valid nibble for DIR=0, lowest for DIR=1.
  - index = 4*nibble + sub-index.
  - Compute out_shift and out_norm with a barrel shifter; register all outputs.
- Padding: padded bits never produce a hit, so index < N always.
- Zero word: out_found=0, out_index=0, out_shift=0, out_norm=0, out_valid still asserts (the result is still delivered).
- Flow control per stage:
  - A stage loads when it is empty or its contents transfer downstream in the same cycle.
  - in_ready = stage-1 empty OR stage 1 advancing. in_ready must not depend combinationally on in_valid.
- Stall: while out_valid=1 and out_ready=0, all out_* are held stable and no data is lost or duplicated. in_ready drops only once every stage is full.
- Simultaneous input accept and output drain while full: both occur; occupancy is unchanged.
- Reset mid-operation: all in-flight words are discarded and no out_valid is produced for them.

Test Plan:
1. N=24, DIR=0, STAGES=2, out_ready=1; in_word=24'h000100 → 2 cycles later: out_found=1, index=8, shift=15, norm=24'h800000.
2. N=24, DIR=0; stream 24'h800000, 24'h00000F, 24'h000000 on consecutive cycles → three consecutive results:
   - index=23, shift=0, norm=24'h800000;
   - index=3, shift=20, norm=24'hF00000;
   - found=0, index=0, shift=0, norm=0.
3. N=24, DIR=1; in_word=24'h0A0000 → index=17, shift=17, norm=24'h000005, found=1.
4. Backpressure: hold out_ready=0 for 5 cycles while driving 4 back-to-back words →
   - in_ready falls after the pipeline fills (2 words accepted);
   - outputs stay stable throughout;
   - on release, all 4 results emerge in order with no gaps or duplicates.
5. N=13, STAGES=1, DIR=0: in_word=13'h1000 → index=12, shift=0, 1-cycle latency. Then in_word=13'h0001 → index=0, shift=12, norm=13'h1000.
6. Assert reset for 1 cycle with 2 words in flight → out_valid=0 next cycle, no stale results afterwards, in_ready=1; the next word processes normally.
